// File: rtl/pipe_trace_buffer_if.sv
// Capture and read-back bus of the trace buffer: one retired-instruction
// record in, one indexed record out.
interface pipe_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              in_valid;
  logic [DATA_W-1:0] in_pc;
  logic [31:0]       in_ir;
  logic [DATA_W-1:0] in_data;
  logic              rd_en;
  logic [PTR_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_pc;
  logic [31:0]       rd_ir;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output in_valid, in_pc, in_ir, in_data, rd_en, rd_idx,
    input  rd_valid, rd_pc, rd_ir, rd_data
  );

  modport slave (
    input  in_valid, in_pc, in_ir, in_data, rd_en, rd_idx,
    output rd_valid, rd_pc, rd_ir, rd_data
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace buffer of {pc, ir, data} records with IR match/mask trigger,
// programmable post-trigger capture and oldest-first indexed read-back.
module pipe_trace_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int POST_LEN = 3,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [31:0]          trig_value,
  input  logic [31:0]          trig_mask,
  pipe_trace_buffer_if.slave   bus,
  output logic [1:0]           state,
  output logic                 triggered,
  output logic                 done,
  output logic [PTR_W:0]       count,
  output logic [PTR_W-1:0]     trig_idx
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] data;
  } rec_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [PTR_W:0]   ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   POST_C  = (PTR_W+1)'(POST_LEN);
  localparam logic [PTR_W-1:0] POST_P  = PTR_W'(POST_LEN);

  state_t           st, st_nxt;
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, post_cnt, rd_phys;
  logic [PTR_W:0]   cnt_inc, trig_calc;
  logic             match, rd_hit;
  logic             wr_en, clr, load_post, dec_post, set_trig, enter_done;

  assign match     = bus.in_valid && ((bus.in_ir & trig_mask) == (trig_value & trig_mask));
  assign cnt_inc   = (count == DEPTH_C) ? count : count + ONE;
  assign trig_calc = cnt_inc - ONE - POST_C;
  // Physical slot uses the pointers as they stand in the request cycle.
  assign rd_phys   = wr_ptr - count[PTR_W-1:0] + bus.rd_idx;
  assign rd_hit    = {1'b0, bus.rd_idx} < count;
  assign state     = st;
  assign done      = (st == DONE);

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    wr_en      = 1'b0;
    clr        = 1'b0;
    load_post  = 1'b0;
    dec_post   = 1'b0;
    set_trig   = 1'b0;
    enter_done = 1'b0;
    if (arm) begin
      clr    = 1'b1;
      st_nxt = ARMED;
    end else begin
      case (st)
        ARMED: if (bus.in_valid) begin
          wr_en = 1'b1;
          if (match) begin
            set_trig = 1'b1;
            if (POST_LEN == 0) begin
              st_nxt     = DONE;
              enter_done = 1'b1;
            end else begin
              st_nxt    = POST;
              load_post = 1'b1;
            end
          end
        end
        POST: if (bus.in_valid) begin
          wr_en    = 1'b1;
          dec_post = 1'b1;
          if (post_cnt == PTR_W'(1)) begin
            st_nxt     = DONE;
            enter_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      trig_idx  <= '0;
      triggered <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= cnt_inc;
      end
      if (load_post)     post_cnt <= POST_P;
      else if (dec_post) post_cnt <= post_cnt - 1'b1;
      if (set_trig)   triggered <= 1'b1;
      if (enter_done) trig_idx  <= trig_calc[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= '{bus.in_pc, bus.in_ir, bus.in_data};
  end

  // Out-of-range reads return zeros; idle cycles hold the last fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_pc    <= '0;
      bus.rd_ir    <= '0;
      bus.rd_data  <= '0;
    end else if (bus.rd_en) begin
      bus.rd_valid <= rd_hit;
      bus.rd_pc    <= rd_hit ? mem[rd_phys].pc   : '0;
      bus.rd_ir    <= rd_hit ? mem[rd_phys].ir   : '0;
      bus.rd_data  <= rd_hit ? mem[rd_phys].data : '0;
    end else begin
      bus.rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: capture tables plus hand-written
// wrap, gap, re-arm and reset sequences.
module tb_pipe_trace_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam logic [31:0] TRIG_IR = 32'h8C010004;
  localparam logic [31:0] NOP_IR  = 32'h00000013;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  st;
    logic [3:0]  cnt;
  } cap_t;

  logic             clk = 1'b0;
  logic             rst, arm;
  logic [31:0]      trig_value, trig_mask;
  logic [1:0]       state;
  logic             triggered, done;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] trig_idx;
  int               n_pass = 0, n_tot = 0;

  pipe_trace_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  pipe_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_LEN(3)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
    .bus(bus), .state(state), .triggered(triggered), .done(done),
    .count(count), .trig_idx(trig_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic [31:0] ir);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_ir    = ir;
    bus.in_data  = pc + 32'h100;
  endtask

  task automatic cap_step(string tag, cap_t c);
    drive(c.v, c.pc, c.ir);
    tick();
    chk({tag, "_state"}, 64'(state), 64'(c.st));
    chk({tag, "_count"}, 64'(count), 64'(c.cnt));
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive(1'b0, 0, 0);
    chk("arm_state", 64'(state), 64'd1);
    chk("arm_count", 64'(count), 64'd0);
  endtask

  task automatic rd_chk(string tag, int idx, logic v, logic [31:0] pc, logic [31:0] ir);
    bus.rd_en  = 1'b1;
    bus.rd_idx = PTR_W'(idx);
    tick();
    chk({tag, "_valid"}, 64'(bus.rd_valid), 64'(v));
    chk({tag, "_pc"},    64'(bus.rd_pc),    64'(pc));
    chk({tag, "_ir"},    64'(bus.rd_ir),    64'(ir));
    chk({tag, "_data"},  64'(bus.rd_data),  v ? 64'(pc + 32'h100) : 64'd0);
  endtask

  cap_t cap[7];
  cap_t gap[6];

  initial begin
    cap[0] = '{1'b1, 32'h00, NOP_IR,  2'd1, 4'd1};
    cap[1] = '{1'b1, 32'h04, NOP_IR,  2'd1, 4'd2};
    cap[2] = '{1'b1, 32'h08, NOP_IR,  2'd1, 4'd3};
    cap[3] = '{1'b1, 32'h0C, TRIG_IR, 2'd2, 4'd4};
    cap[4] = '{1'b1, 32'h10, NOP_IR,  2'd2, 4'd5};
    cap[5] = '{1'b1, 32'h14, TRIG_IR, 2'd2, 4'd6};
    cap[6] = '{1'b1, 32'h18, NOP_IR,  2'd3, 4'd7};
    // in_valid pattern 1,0,0,1,0,1 in POST; gap cycles carry a matching IR
    gap[0] = '{1'b1, 32'h04, NOP_IR,  2'd2, 4'd2};
    gap[1] = '{1'b0, 32'h08, TRIG_IR, 2'd2, 4'd2};
    gap[2] = '{1'b0, 32'h08, TRIG_IR, 2'd2, 4'd2};
    gap[3] = '{1'b1, 32'h08, NOP_IR,  2'd2, 4'd3};
    gap[4] = '{1'b0, 32'h0C, NOP_IR,  2'd2, 4'd3};
    gap[5] = '{1'b1, 32'h0C, NOP_IR,  2'd3, 4'd4};

    rst = 1'b1; arm = 1'b0;
    trig_mask = 32'hFC000000; trig_value = 32'h8C000000;
    bus.rd_en = 1'b0; bus.rd_idx = '0;
    drive(1'b0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_trig_idx", 64'(trig_idx), 64'd0);

    // IDLE ignores samples
    drive(1'b1, 32'h44, TRIG_IR);
    tick();
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_state", 64'(state), 64'd0);

    // basic capture
    do_arm();
    for (int i = 0; i < 7; i++) cap_step($sformatf("cap%0d", i), cap[i]);
    drive(1'b0, 0, 0);
    chk("cap_done", 64'(done), 64'd1);
    chk("cap_trig", 64'(triggered), 64'd1);
    chk("cap_trig_idx", 64'(trig_idx), 64'd3);
    drive(1'b1, 32'h1C, TRIG_IR);
    tick();
    drive(1'b0, 0, 0);
    chk("done_no_write", 64'(count), 64'd7);
    rd_chk("rd_trig", 3, 1'b1, 32'h0C, TRIG_IR);
    rd_chk("rd_oob", 7, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++)
      rd_chk($sformatf("rd_b2b%0d", i), i, 1'b1, 32'(i * 4), cap[i].ir);
    bus.rd_en = 1'b0;
    tick();
    chk("rd_idle_valid", 64'(bus.rd_valid), 64'd0);
    chk("rd_idle_hold", 64'(bus.rd_pc), 64'h18);

    // wrap: 16 writes into 8 entries
    do_arm();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4), (i == 12) ? TRIG_IR : NOP_IR);
      tick();
    end
    drive(1'b0, 0, 0);
    chk("wrap_state", 64'(state), 64'd3);
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_trig_idx", 64'(trig_idx), 64'd4);
    rd_chk("wrap_rd0", 0, 1'b1, 32'h20, NOP_IR);
    rd_chk("wrap_rd7", 7, 1'b1, 32'h3C, NOP_IR);
    rd_chk("wrap_rd4", 4, 1'b1, 32'h30, TRIG_IR);
    bus.rd_en = 1'b0;

    // gaps in POST
    do_arm();
    drive(1'b1, 32'h00, TRIG_IR);
    tick();
    chk("gap_trig_state", 64'(state), 64'd2);
    for (int i = 0; i < 6; i++) cap_step($sformatf("gap%0d", i), gap[i]);
    drive(1'b0, 0, 0);
    chk("gap_trig_idx", 64'(trig_idx), 64'd0);

    // re-arm mid-POST with a live sample, then reset mid-POST
    do_arm();
    drive(1'b1, 32'h00, TRIG_IR);
    tick();
    drive(1'b1, 32'h04, NOP_IR);
    tick();
    chk("rearm_pre_state", 64'(state), 64'd2);
    arm = 1'b1;
    drive(1'b1, 32'h99, NOP_IR);
    tick();
    arm = 1'b0;
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_count", 64'(count), 64'd0);
    chk("rearm_trig", 64'(triggered), 64'd0);
    drive(1'b1, 32'h40, NOP_IR);
    tick();
    drive(1'b0, 0, 0);
    chk("rearm_count1", 64'(count), 64'd1);
    rd_chk("rearm_rd0", 0, 1'b1, 32'h40, NOP_IR);
    bus.rd_en = 1'b0;
    drive(1'b1, 32'h44, TRIG_IR);
    tick();
    chk("rst_mid_pre", 64'(state), 64'd2);
    rst = 1'b1;
    drive(1'b1, 32'h48, NOP_IR);
    tick();
    rst = 1'b0;
    drive(1'b0, 0, 0);
    chk("rst_mid_state", 64'(state), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_trig", 64'(triggered), 64'd0);
    chk("rst_mid_rd_pc", 64'(bus.rd_pc), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
